// File: rtl/mlp_mac_datapath.sv
// mlp_mac_datapath: int8 weight x activation MAC with ReLU/shift requantization and SRAM write-back.
// Build option MLP_MAC_SAT_EN: saturate the requantized value at 127 instead of keeping its low 8 bits.
module mlp_mac_datapath #(
    parameter int ACC_W = 24,
    parameter int SHIFT = 7
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    w_ren_i,
    input  logic                    x_ren_i,
    input  logic                    x_sel_i,
    input  logic signed [7:0]       w_rdata_i,
    input  logic signed [7:0]       x_rdata0_i,
    input  logic signed [7:0]       x_rdata1_i,
    input  logic                    partial_sum_store_i,
    input  logic                    x_sram_write_back_i,
    output logic                    x_wen_o,
    output logic signed [7:0]       x_wdata_o,
    output logic signed [ACC_W-1:0] acc_o
);

    logic                    issue;
    logic                    valid_q, valid_d;
    logic                    x_sel_q, x_sel_d;
    logic signed [7:0]       x_mux;
    logic signed [15:0]      product;
    logic signed [ACC_W-1:0] product_ext;
    logic signed [ACC_W-1:0] store_sum;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0]        relu;
    logic [ACC_W-1:0]        shifted;
    logic [7:0]              requant;
    logic [7:0]              result_q, result_d;
    logic                    x_wen_q, x_wen_d;

    // Only a paired weight/activation read forms a valid operand pair.
    assign issue   = w_ren_i & x_ren_i;
    assign valid_d = issue;
    assign x_sel_d = issue ? x_sel_i : x_sel_q;

    // Read data returns one cycle after the issue, so the bank is chosen by the select captured then.
    assign x_mux       = x_sel_q ? x_rdata1_i : x_rdata0_i;
    assign product     = w_rdata_i * x_mux;
    assign product_ext = {{(ACC_W-16){product[15]}}, product};

    // The sum seen by a store already includes a product arriving in the same cycle.
    assign store_sum = acc_q + (valid_q ? product_ext : {ACC_W{1'b0}});
    assign acc_d     = partial_sum_store_i ? {ACC_W{1'b0}} : store_sum;

    always_comb begin
        relu    = store_sum[ACC_W-1] ? {ACC_W{1'b0}} : store_sum;
        shifted = relu >> SHIFT;
`ifdef MLP_MAC_SAT_EN
        requant = (shifted > ACC_W'(127)) ? 8'd127 : shifted[7:0];
`else
        requant = shifted[7:0];
`endif
    end

`ifndef MLP_MAC_SAT_EN
    logic unused_shifted_hi;
    assign unused_shifted_hi = ^shifted[ACC_W-1:8];
`endif

    // Result updates on the same edge as the store, so a coincident write-back sees the new value.
    assign result_d = partial_sum_store_i ? requant : result_q;
    assign x_wen_d  = x_sram_write_back_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= 1'b0;
            x_sel_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            x_wen_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            x_sel_q  <= x_sel_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            x_wen_q  <= x_wen_d;
        end
    end

    assign x_wen_o   = x_wen_q;
    assign x_wdata_o = result_q;
    assign acc_o     = acc_q;

endmodule

// File: tb/tb_mlp_mac_datapath.sv
// Directed bench for mlp_mac_datapath: two instances (SHIFT=7 and SHIFT=0) share one stimulus stream.
module tb_mlp_mac_datapath;
    localparam int ACC_W = 24;

`ifdef MLP_MAC_SAT_EN
    localparam logic [7:0] SAT7    = 8'd127; // 4129024 >> 7 = 32258 -> 127
    localparam logic [7:0] SAT0    = 8'd127; // 4129024 -> 127
    localparam logic [7:0] S0_1024 = 8'd127; // 1024 -> 127
    localparam logic [7:0] S0_256  = 8'd127; // 256 -> 127
`else
    localparam logic [7:0] SAT7    = 8'd2;   // 32258 mod 256
    localparam logic [7:0] SAT0    = 8'd0;   // 4129024 mod 256
    localparam logic [7:0] S0_1024 = 8'd0;   // 1024 mod 256
    localparam logic [7:0] S0_256  = 8'd0;   // 256 mod 256
`endif

    // clock / reset
    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    logic              w_ren_i, x_ren_i, x_sel_i;
    logic signed [7:0] w_rdata_i, x_rdata0_i, x_rdata1_i;
    logic              partial_sum_store_i, x_sram_write_back_i;
    logic              x_wen7, x_wen0;
    logic signed [7:0] wdata7, wdata0;
    logic signed [ACC_W-1:0] acc7, acc0;

    mlp_mac_datapath #(.ACC_W(ACC_W), .SHIFT(7)) dut_s7 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .w_ren_i(w_ren_i), .x_ren_i(x_ren_i), .x_sel_i(x_sel_i),
        .w_rdata_i(w_rdata_i), .x_rdata0_i(x_rdata0_i), .x_rdata1_i(x_rdata1_i),
        .partial_sum_store_i(partial_sum_store_i), .x_sram_write_back_i(x_sram_write_back_i),
        .x_wen_o(x_wen7), .x_wdata_o(wdata7), .acc_o(acc7)
    );

    mlp_mac_datapath #(.ACC_W(ACC_W), .SHIFT(0)) dut_s0 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .w_ren_i(w_ren_i), .x_ren_i(x_ren_i), .x_sel_i(x_sel_i),
        .w_rdata_i(w_rdata_i), .x_rdata0_i(x_rdata0_i), .x_rdata1_i(x_rdata1_i),
        .partial_sum_store_i(partial_sum_store_i), .x_sram_write_back_i(x_sram_write_back_i),
        .x_wen_o(x_wen0), .x_wdata_o(wdata0), .acc_o(acc0)
    );

    // scoreboard
    logic [7:0] exp7_q[$];
    logic [7:0] exp0_q[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk_i) begin
        if (x_wen7 === 1'b1) begin
            if (exp7_q.size() == 0) check("s7 unexpected x_wen_o pulse", 32'd1, 32'd0);
            else check("s7 x_wdata_o at pulse", 32'($unsigned(wdata7)), 32'(exp7_q.pop_front()));
        end
        if (x_wen0 === 1'b1) begin
            if (exp0_q.size() == 0) check("s0 unexpected x_wen_o pulse", 32'd1, 32'd0);
            else check("s0 x_wdata_o at pulse", 32'($unsigned(wdata0)), 32'(exp0_q.pop_front()));
        end
    end

    // driver: read data given here answers the issue of the previous cycle
    task automatic step(input logic wr, input logic xr, input logic sel,
                        input logic signed [7:0] wd, input logic signed [7:0] x0d,
                        input logic signed [7:0] x1d, input logic st, input logic wb,
                        input logic [7:0] e7, input logic [7:0] e0);
        w_ren_i             = wr;
        x_ren_i             = xr;
        x_sel_i             = sel;
        w_rdata_i           = wd;
        x_rdata0_i          = x0d;
        x_rdata1_i          = x1d;
        partial_sum_store_i = st;
        x_sram_write_back_i = wb;
        if (wb) begin
            exp7_q.push_back(e7);
            exp0_q.push_back(e0);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 8'sd0, 8'sd0, 8'sd0, 1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    initial begin
        rst_ni = 1'b0;
        w_ren_i = 1'b0; x_ren_i = 1'b0; x_sel_i = 1'b0;
        w_rdata_i = '0; x_rdata0_i = '0; x_rdata1_i = '0;
        partial_sum_store_i = 1'b0; x_sram_write_back_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        check("reset x_wen_o", 32'(x_wen7), 32'd0);
        check("reset x_wdata_o", 32'($unsigned(wdata7)), 32'd0);
        check("reset acc_o", 32'($unsigned(acc7)), 32'd0);
        check("reset s0 acc_o", 32'($unsigned(acc0)), 32'd0);
        rst_ni = 1'b1;
        idle(2);

        // basic dot product: 4 x (16*16) = 1024
        step(1'b1, 1'b1, 1'b0, 8'sd0, 8'sd0, 8'sd0, 1'b0, 1'b0, 8'd0, 8'd0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 8'sd16, 8'sd16, 8'sd0, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'sd16, 8'sd16, 8'sd0, 1'b0, 1'b0, 8'd0, 8'd0);
        check("basic acc_o", 32'($unsigned(acc7)), 32'd1024);
        check("basic s0 acc_o", 32'($unsigned(acc0)), 32'd1024);
        step(1'b0, 1'b0, 1'b0, 8'sd0, 8'sd0, 8'sd0, 1'b1, 1'b0, 8'd0, 8'd0);
        check("acc_o cleared by store", 32'($unsigned(acc7)), 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'sd0, 8'sd0, 8'sd0, 1'b0, 1'b1, 8'd8, S0_1024);
        idle(3);
        check("x_wdata_o holds result", 32'($unsigned(wdata7)), 32'd8);

        // ReLU: 2 x (-128*100) < 0 -> 0; store and write-back coincide
        step(1'b1, 1'b1, 1'b0, 8'sd0, 8'sd0, 8'sd0, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b1, 1'b1, 1'b0, -8'sd128, 8'sd100, 8'sd0, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b0, 1'b0, 1'b0, -8'sd128, 8'sd100, 8'sd0, 1'b1, 1'b1, 8'd0, 8'd0);
        idle(3);
        check("relu x_wdata_o", 32'($unsigned(wdata7)), 32'd0);

        // saturation: 256 x (127*127) = 4129024
        for (int i = 0; i <= 256; i++)
            step(i < 256, i < 256, 1'b0, (i > 0) ? 8'sd127 : 8'sd0, (i > 0) ? 8'sd127 : 8'sd0,
                 8'sd0, 1'b0, 1'b0, 8'd0, 8'd0);
        check("sat acc_o", 32'($unsigned(acc7)), 32'd4129024);
        step(1'b0, 1'b0, 1'b0, 8'sd0, 8'sd0, 8'sd0, 1'b1, 1'b0, 8'd0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'sd0, 8'sd0, 8'sd0, 1'b0, 1'b1, SAT7, SAT0);
        idle(3);

        // bank switch: sel 0,1,0,1 with bank0=1, bank1=3, w=1 -> 8; live select opposes registered one
        step(1'b1, 1'b1, 1'b0, 8'sd0, 8'sd0, 8'sd0, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b1, 1'b1, 1'b1, 8'sd1, 8'sd1, 8'sd3, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b1, 1'b1, 1'b0, 8'sd1, 8'sd1, 8'sd3, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b1, 1'b1, 1'b1, 8'sd1, 8'sd1, 8'sd3, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'sd1, 8'sd1, 8'sd3, 1'b0, 1'b0, 8'd0, 8'd0);
        // lone weight or activation strobes must not contribute
        step(1'b1, 1'b0, 1'b0, 8'sd0, 8'sd0, 8'sd0, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b0, 1'b1, 1'b1, 8'sd50, 8'sd50, 8'sd50, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'sd50, 8'sd50, 8'sd50, 1'b0, 1'b0, 8'd0, 8'd0);
        check("bank acc_o", 32'($unsigned(acc0)), 32'd8);
        step(1'b0, 1'b0, 1'b0, 8'sd0, 8'sd0, 8'sd0, 1'b1, 1'b0, 8'd0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'sd0, 8'sd0, 8'sd0, 1'b0, 1'b1, 8'd0, 8'd8);
        idle(3);

        // coincident: 125*2 + final 2*3 in store cycle = 256; then back-to-back write-backs
        step(1'b1, 1'b1, 1'b0, 8'sd0, 8'sd0, 8'sd0, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b1, 1'b1, 1'b0, 8'sd125, 8'sd2, 8'sd0, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'sd2, 8'sd3, 8'sd0, 1'b1, 1'b1, 8'd2, S0_256);
        check("coincident acc_o cleared", 32'($unsigned(acc7)), 32'd0);
        check("coincident s0 acc_o cleared", 32'($unsigned(acc0)), 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'sd0, 8'sd0, 8'sd0, 1'b0, 1'b1, 8'd2, S0_256);
        step(1'b0, 1'b0, 1'b0, 8'sd0, 8'sd0, 8'sd0, 1'b0, 1'b1, 8'd2, S0_256);
        idle(3);
        check("acc_o stays 0", 32'($unsigned(acc7)), 32'd0);

        // reset mid dot-product with a write-back request in flight
        step(1'b1, 1'b1, 1'b0, 8'sd0, 8'sd0, 8'sd0, 1'b0, 1'b0, 8'd0, 8'd0);
        w_rdata_i = 8'sd9; x_rdata0_i = 8'sd9; x_sram_write_back_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        w_ren_i = 1'b0; x_ren_i = 1'b0; x_sram_write_back_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("mid reset x_wen_o", 32'(x_wen7), 32'd0);
        check("mid reset x_wdata_o", 32'($unsigned(wdata7)), 32'd0);
        rst_ni = 1'b1;
        idle(4);
        check("post reset acc_o", 32'($unsigned(acc7)), 32'd0);
        check("s7 queue drained", 32'(exp7_q.size()), 32'd0);
        check("s0 queue drained", 32'(exp0_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mlp_mac_datapath.md
MLP_MAC_DATAPATH -- requirements
Module: mlp_mac_datapath

Interface
REQ-001 Parameter: ACC_W, default 24, accumulator width in bits, signed.
REQ-002 Parameter: SHIFT, default 7, right-shift applied to the accumulator before requantization.
REQ-003 Port: clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_ni  in  1  asynchronous, active-low reset.
REQ-005 Port: w_ren_i  in  1  weight SRAM read strobe from the controller.
REQ-006 Port: x_ren_i  in  1  activation SRAM read strobe from the controller.
REQ-007 Port: x_sel_i  in  1  activation bank select (0: bank0, 1: bank1), sampled with x_ren_i.
REQ-008 Port: w_rdata_i  in  8  signed weight, valid one cycle after w_ren_i.
REQ-009 Port: x_rdata0_i / x_rdata1_i  in  8 each  signed activations from bank0/bank1, valid one cycle after x_ren_i.
REQ-010 Port: partial_sum_store_i  in  1  close the current dot product and capture the requantized result.
REQ-011 Port: x_sram_write_back_i  in  1  request write-back of the captured result.
REQ-012 Port: x_wen_o  out  1  activation SRAM write enable, one-cycle pulse.
REQ-013 Port: x_wdata_o  out  8  signed requantized result.
REQ-014 Port: acc_o  out  ACC_W  current accumulator value, for debug.

Function
REQ-015 A read issue is registered when w_ren_i and x_ren_i are both high in cycle t; data_valid is high in cycle t+1 only.
REQ-016 A read issue with only one of w_ren_i or x_ren_i high shall be ignored.
REQ-017 x_sel_i shall be registered together with the issue; the x bank multiplexer in cycle t+1 shall use the registered value, never the live x_sel_i.
REQ-018 When data_valid is high, product = w * x (16-bit signed), sign-extended to ACC_W and added to the accumulator; no overflow handling is needed for ACC_W >= 24 with at most 256 terms.
REQ-019 When partial_sum_store_i is high in cycle t, the captured sum shall be acc + (data_valid ? product : 0).
REQ-020 The requantized value computed from the captured sum shall be loaded into the result register.
REQ-021 In the same cycle as REQ-019, the accumulator shall clear to 0; a simultaneous product is consumed by the store and is not carried over.
REQ-022 Requantization: ReLU (negative -> 0), then arithmetic shift right by SHIFT, then the conversion defined in REQ-031/REQ-032.
REQ-023 x_sram_write_back_i high in cycle t shall produce x_wen_o high in cycle t+1 for exactly one cycle, with x_wdata_o equal to the result register.
REQ-024 If x_sram_write_back_i and partial_sum_store_i are both high in cycle t, the write-back shall use the new result from that store.
REQ-025 x_wdata_o shall hold the result register value continuously between stores.
REQ-026 Back-to-back write-backs on consecutive cycles shall each produce one x_wen_o pulse.

Reset
REQ-027 On rst_ni low, asynchronously: accumulator = 0, data_valid = 0, registered bank select = 0, result register = 0, x_wen_o = 0.
REQ-028 Consequently, at reset x_wdata_o = 0 and acc_o = 0.
REQ-029 Reset asserted mid dot-product shall discard all pending issues; no x_wen_o pulse shall appear after reset deasserts unless newly requested.

Configuration
REQ-030 Macro MLP_MAC_SAT_EN selects the requantization conversion.
REQ-031 With MLP_MAC_SAT_EN defined: a shifted value > 127 shall saturate to 127.
REQ-032 Without MLP_MAC_SAT_EN: the conversion keeps the low 8 bits of the shifted value (wrap-around).

Verification
REQ-033 Reset check: hold rst_ni low 10 cycles -> x_wen_o = 0, x_wdata_o = 0, acc_o = 0.
REQ-034 Basic dot product: 4 issues with w = 16, x = 16, bank0, then store, then write-back -> acc 1024, result 8, x_wen_o pulse with x_wdata_o = 8.
REQ-035 ReLU: 2 issues with w = -128, x = 100, then store -> x_wdata_o = 0.
REQ-036 Saturation, 256 issues with w = 127, x = 127 (sum 4129024):
  - with MLP_MAC_SAT_EN -> x_wdata_o = 127;
  - without MLP_MAC_SAT_EN -> x_wdata_o = 32258 mod 256 = 2.
REQ-037 Bank switch: alternate x_sel_i 0/1 each issue, x_rdata0 = 1, x_rdata1 = 3, w = 1, 4 issues, then store with SHIFT = 0 -> result 8.
REQ-038 Coincident events: a last product (w = 2, x = 3) valid in the same cycle as store and write-back -> result includes 6; x_wen_o pulses next cycle with the new value; acc_o = 0 afterwards.
